// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S serializer with one-pair holding register; AUDIO_I2S_TX_MUTE_ON_UNDERRUN_EN mutes on underrun
module audio_i2s_tx #(
  parameter int SAMPLE_W = 16,
  parameter int BCLK_DIV = 4
) (
  input  logic                pxlClk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] sampleL,
  input  logic [SAMPLE_W-1:0] sampleR,
  input  logic                sampleValid,
  output logic                sampleReady,
  output logic                BCLK,
  output logic                LRCK,
  output logic                SDAT,
  output logic                underrun
);
  localparam int FW = 2 * SAMPLE_W;
  localparam int DW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int SW = $clog2(FW);
  logic [DW-1:0] div_cnt, div_nxt;
  logic [SW-1:0] slot, slot_nxt;
  logic [FW-1:0] frame, frame_nxt, hold, hold_nxt;
  logic full, full_nxt, bclk_nxt, ur_nxt, wrap, fall, load, acc;
  // divider, slot advance on falling steps, frame load at slot wrap and holding-register handshake
  always_comb begin
    wrap = div_cnt == DW'(BCLK_DIV - 1);
    fall = wrap && BCLK;
    load = fall && slot == SW'(FW - 1);
    acc = sampleValid && !full;
    div_nxt = wrap ? '0 : div_cnt + DW'(1);
    bclk_nxt = BCLK ^ wrap;
    slot_nxt = fall ? (slot == SW'(FW - 1) ? '0 : slot + SW'(1)) : slot;
`ifdef AUDIO_I2S_TX_MUTE_ON_UNDERRUN_EN
    frame_nxt = load ? (full ? hold : '0) : frame;
`else
    frame_nxt = (load && full) ? hold : frame;
`endif
    ur_nxt = load && !full;
    hold_nxt = acc ? {sampleL, sampleR} : hold;
    full_nxt = acc || (full && !load);
  end
  // state registers; a reset abandons the current frame and discards the held pair
  always_ff @(posedge pxlClk) begin
    if (rst) begin
      div_cnt <= '0;
      BCLK <= 1'b0;
      slot <= SW'(FW - 1);
      frame <= '0;
      hold <= '0;
      full <= 1'b0;
      underrun <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      BCLK <= bclk_nxt;
      slot <= slot_nxt;
      frame <= frame_nxt;
      hold <= hold_nxt;
      full <= full_nxt;
      underrun <= ur_nxt;
    end
  end
  assign sampleReady = ~full;
  assign SDAT = frame[SW'(FW - 1) - slot];
  assign LRCK = (slot >= SW'(SAMPLE_W - 1)) && (slot <= SW'(FW - 2));
endmodule

// File: tb/tb_audio_i2s_tx.sv
// tb_audio_i2s_tx: randomized and directed checks of audio_i2s_tx against a frame-level model
module tb_audio_i2s_tx;
  localparam int W = 16;
  localparam int D = 2;
  localparam int FW = 2 * W;
  localparam int FC = 2 * D;
  logic pxlClk = 1'b0;
  logic rst = 1'b1;
  logic valid = 1'b0;
  logic [W-1:0] l = '0, r = '0;
  logic ready, bclk, lrck, sdat, ur;
  int checks = 0, failures = 0;
  int e = 0, accepts = 0;
  logic hfull = 1'b0, bclk_prev = 1'b0;
  logic [FW-1:0] hold = '0, cur = '0, rx = '0;
  logic [W-1:0] cur_l, cur_r;

  audio_i2s_tx #(.SAMPLE_W(W), .BCLK_DIV(D)) dut (
    .pxlClk(pxlClk), .rst(rst), .sampleL(l), .sampleR(r), .sampleValid(valid),
    .sampleReady(ready), .BCLK(bclk), .LRCK(lrck), .SDAT(sdat), .underrun(ur)
  );

  always #5 pxlClk = ~pxlClk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at e=%0d: got %h expected %h", name, e, act, exp);
    end
  endtask

  // one clock: model the edge from the pair-level rules, then compare every output
  task automatic tick();
    logic acc, load, m_ur;
    int f, s;
    acc = valid && !hfull && !rst;
    m_ur = 1'b0;
    @(posedge pxlClk);
    if (rst) begin
      e = 0; hfull = 1'b0; hold = '0; cur = '0;
    end else begin
      e++;
      load = (e % FC == 0) && (((e / FC) - 1) % FW == 0);
      m_ur = load && !hfull;
      if (load) begin
        if (hfull) begin
          cur = hold; hfull = 1'b0;
        end
`ifdef AUDIO_I2S_TX_MUTE_ON_UNDERRUN_EN
        else cur = '0;
`endif
      end
      if (acc) begin
        hold = {l, r}; hfull = 1'b1; accepts++;
      end
    end
    #1;
    f = e / FC;
    s = (f + FW - 1) % FW;
    cur_l = cur[FW-1:W];
    cur_r = cur[W-1:0];
    chk("bclk", 32'(bclk), 32'((e / D) % 2));
    chk("lrck", 32'(lrck), 32'(s >= W - 1 && s <= FW - 2));
    chk("sdat", 32'(sdat), 32'(s < W ? cur_l[W-1-s] : cur_r[W-1-(s-W)]));
    chk("underrun", 32'(ur), 32'(m_ur));
    chk("ready", 32'(ready), 32'(!hfull));
    if (!bclk_prev && bclk) rx = {rx[FW-2:0], sdat};
    bclk_prev = bclk;
  endtask

  task automatic run_to(input int target);
    for (int i = 0; i < 5000 && e < target; i++) tick();
    chk("reach", 32'(e), 32'(target));
  endtask

  task automatic reset_pulse();
    rst = 1'b1; valid = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    l = a; r = b; valid = 1'b1;
    tick();
    valid = 1'b0;
  endtask

  initial begin
    int a0;
    // reset and idle
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_bclk", 32'(bclk), 32'd0);
    rst = 1'b0;
    run_to(3);
    chk("idle_no_ur_early", 32'(ur), 32'd0);
    run_to(4);
    chk("idle_ur_first", 32'(ur), 32'd1);
    run_to(132);
    chk("idle_ur_second", 32'(ur), 32'd1);
    run_to(260);
    // single pair preloaded before the first load
    reset_pulse();
    send(16'hA5C3, 16'h8001);
    run_to(63);
    chk("lrck_slot14", 32'(lrck), 32'd0);
    run_to(64);
    chk("lrck_slot15", 32'(lrck), 32'd1);
    run_to(128);
    chk("lrck_slot31", 32'(lrck), 32'd0);
    run_to(130);
    chk("rx_pair", rx, 32'hA5C38001);
    // underrun after one pair
    reset_pulse();
    send(16'h1234, 16'h5678);
    run_to(130);
    chk("rx_first", rx, 32'h12345678);
    run_to(132);
    chk("ur_starve", 32'(ur), 32'd1);
    run_to(258);
`ifdef AUDIO_I2S_TX_MUTE_ON_UNDERRUN_EN
    chk("rx_starved", rx, 32'h0);
`else
    chk("rx_starved", rx, 32'h12345678);
`endif
    // accept on the load cycle with holding empty
    reset_pulse();
    run_to(3);
    send(16'hBEEF, 16'h0F0F);
    chk("same_cycle_ur", 32'(ur), 32'd1);
    chk("same_cycle_ready", 32'(ready), 32'd0);
    run_to(258);
    chk("rx_same_cycle", rx, 32'hBEEF0F0F);
    // continuous stream
    reset_pulse();
    valid = 1'b1;
    for (int i = 0; i < 4000 && e < 4; i++) begin
      l = 16'(accepts); r = ~16'(accepts); tick();
    end
    a0 = accepts;
    for (int i = 0; i < 4000 && e < 4 + 4 * 128; i++) begin
      l = 16'(accepts); r = ~16'(accepts); tick();
    end
    chk("stream_accepts", 32'(accepts - a0), 32'd4);
    valid = 1'b0;
    // reset mid-frame at slot 10
    reset_pulse();
    send(16'hCAFE, 16'hF00D);
    run_to(44);
    rst = 1'b1;
    tick();
    chk("mid_bclk", 32'(bclk), 32'd0);
    chk("mid_lrck", 32'(lrck), 32'd0);
    chk("mid_sdat", 32'(sdat), 32'd0);
    chk("mid_ready", 32'(ready), 32'd1);
    chk("mid_ur", 32'(ur), 32'd0);
    rst = 1'b0;
    run_to(4);
    chk("mid_ur_after", 32'(ur), 32'd1);
    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      valid = ($urandom_range(0, 3) == 0);
      l = 16'($urandom);
      r = 16'($urandom);
      rst = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
